// File: rtl/spi_cmd_decoder_if.sv
// Byte handshake between the SPI slave shift stage and spi_cmd_decoder.
// The slave modport is the decoder side; master is the SPI shift stage.
interface spi_cmd_decoder_if;
    logic       iRxReady;
    logic [7:0] iRx;
    logic       iSPICS;
    logic       oTxReady;
    logic [7:0] oTx;

    modport slave  (input  iRxReady, iRx, iSPICS, output oTxReady, oTx);
    modport master (output iRxReady, iRx, iSPICS, input  oTxReady, oTx);
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: parses {cmd, data...} frames into a small register file.
// Optional SPI_CMD_AUTOINC_EN enables multi-byte bursts with address wrap.
module spi_cmd_decoder #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                  sysclk,
    input  logic                  iRstN,
    spi_cmd_decoder_if.slave      bus,
    output logic [8*NUM_REGS-1:0] oRegs,
    output logic                  oWrStrobe,
    output logic [5:0]            oWrAddr,
    output logic                  oFrameErr
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [6:0] NREG7  = 7'(NUM_REGS);
    localparam logic [6:0] ID_ADR = 7'h7F;

    logic [1:0] rx_sync, cs_sync;
    logic       rx_prev, cs_prev;
    logic       byte_ev, frame_end;

    state_t     state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic       do_wr, do_load, err_set;
    logic [7:0] reply;
    logic [NUM_REGS-1:0][7:0] regs;

    // Edge detect is registered, so events act 3 cycles after the raw edge is seen.
    always_ff @(posedge sysclk or negedge iRstN) begin
        if (!iRstN) begin
            rx_sync   <= 2'b00;
            rx_prev   <= 1'b0;
            byte_ev   <= 1'b0;
            cs_sync   <= 2'b11;
            cs_prev   <= 1'b1;
            frame_end <= 1'b0;
        end else begin
            rx_sync   <= {rx_sync[0], bus.iRxReady};
            rx_prev   <= rx_sync[1];
            byte_ev   <= rx_sync[1] & ~rx_prev;
            cs_sync   <= {cs_sync[0], bus.iSPICS};
            cs_prev   <= cs_sync[1];
            frame_end <= cs_sync[1] & ~cs_prev;
        end
    end

`ifdef SPI_CMD_AUTOINC_EN
    localparam logic [6:0] LAST7 = 7'(NUM_REGS - 1);

    function automatic logic [6:0] adv(input logic [6:0] a);
        if (a == LAST7)     return 7'd0;
        else if (a < NREG7) return a + 7'd1;
        return a;
    endfunction
`endif

    always_ff @(posedge sysclk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            addr_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        do_wr   = 1'b0;
        do_load = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: if (byte_ev) begin
                addr_d = bus.iRx[6:0];
                if (bus.iRx[7]) begin
                    do_load = 1'b1;
                    state_d = READ;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: if (byte_ev) begin
                if (addr_q < NREG7) do_wr   = 1'b1;
                else                err_set = 1'b1;
`ifdef SPI_CMD_AUTOINC_EN
                addr_d = adv(addr_q);
`else
                state_d = DONE;
`endif
            end
            READ: if (byte_ev) begin
`ifdef SPI_CMD_AUTOINC_EN
                addr_d  = adv(addr_q);
                do_load = 1'b1;
`else
                state_d = DONE;
`endif
            end
            default: ;
        endcase
        // Same-cycle byte is still processed above; the frame end only overrides state.
        if (frame_end) state_d = IDLE;
    end

    // Reply source follows the address being entered, not the one being left.
    always_comb begin
        reply = 8'hFF;
        if (addr_d == ID_ADR) reply = ID_VALUE;
        else
            for (int n = 0; n < NUM_REGS; n++)
                if (addr_d == 7'(n)) reply = regs[n];
    end

    always_ff @(posedge sysclk or negedge iRstN) begin
        if (!iRstN) begin
            regs         <= '0;
            oWrStrobe    <= 1'b0;
            oWrAddr      <= 6'd0;
            oFrameErr    <= 1'b0;
            bus.oTxReady <= 1'b0;
            bus.oTx      <= 8'h00;
        end else begin
            for (int n = 0; n < NUM_REGS; n++)
                if (do_wr && addr_q == 7'(n)) regs[n] <= bus.iRx;
            oWrStrobe    <= do_wr;
            if (do_wr) oWrAddr <= addr_q[5:0];
            oFrameErr    <= oFrameErr | err_set;
            bus.oTxReady <= do_load;
            if (do_load) bus.oTx <= reply;
        end
    end

    assign oRegs = regs;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder (NUM_REGS=8): write, read, ID, range and reset cases.
module tb_spi_cmd_decoder;
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysclk = ~sysclk;

    spi_cmd_decoder_if bus();
    logic [63:0] regs;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic        frame_err;

    spi_cmd_decoder #(.NUM_REGS(8), .ID_VALUE(8'hA5)) dut (
        .sysclk    (sysclk),
        .iRstN     (rst_n),
        .bus       (bus.slave),
        .oRegs     (regs),
        .oWrStrobe (wr_strobe),
        .oWrAddr   (wr_addr),
        .oFrameErr (frame_err)
    );

    int checks = 0, errors = 0;
    int tx_cnt = 0, wr_cnt = 0;
    logic [5:0] last_wa = '0;
    int lat0, w0, t0;
    logic [7:0] tx0;
    logic [63:0] exp_regs;

    always @(negedge sysclk) begin
        if (bus.oTxReady) tx_cnt++;
        if (wr_strobe) begin
            wr_cnt++;
            last_wa = wr_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Byte held 3 cycles, 12-cycle slot; reports cycles to the first reply pulse.
    task automatic send_byte(input logic [7:0] b, output int l, output logic [7:0] tx);
        bus.iRx      = b;
        bus.iRxReady = 1'b1;
        l  = 0;
        tx = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            @(negedge sysclk);
            if (k == 3) bus.iRxReady = 1'b0;
            if (bus.oTxReady && l == 0) begin
                l  = k;
                tx = bus.oTx;
            end
        end
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, input int n);
        int l;
        logic [7:0] t;
        bus.iSPICS = 1'b0;
        repeat (4) @(negedge sysclk);
        send_byte(b0, lat0, tx0);
        if (n > 1) send_byte(b1, l, t);
        if (n > 2) send_byte(b2, l, t);
        bus.iSPICS = 1'b1;
        repeat (8) @(negedge sysclk);
    endtask

    initial begin
        bus.iRxReady = 1'b0;
        bus.iRx      = 8'h00;
        bus.iSPICS   = 1'b1;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);

        // Reset in the middle of a write frame
        bus.iSPICS = 1'b0;
        repeat (4) @(negedge sysclk);
        send_byte(8'h03, lat0, tx0);
        bus.iRx      = 8'h5A;
        bus.iRxReady = 1'b1;
        @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        chk("rst_txready", bus.oTxReady, 0);
        chk("rst_tx",      bus.oTx, 0);
        chk("rst_regs",    regs, 0);
        chk("rst_strobe",  wr_strobe, 0);
        chk("rst_wraddr",  wr_addr, 0);
        chk("rst_ferr",    frame_err, 0);
        @(negedge sysclk);
        bus.iRxReady = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);
        bus.iSPICS = 1'b1;
        repeat (8) @(negedge sysclk);
        chk("post_rst_regs", regs, 0);
        chk("post_rst_wr",   wr_cnt, 0);

        exp_regs = '0;
        w0 = wr_cnt;
        frame(8'h02, 8'h5C, 8'h00, 2);
        exp_regs[23:16] = 8'h5C;
        chk("wr2_regs",   regs, exp_regs);
        chk("wr2_strobe", wr_cnt - w0, 1);
        chk("wr2_addr",   last_wa, 2);
        chk("wr2_ferr",   frame_err, 0);

        t0 = tx_cnt;
        frame(8'h82, 8'h00, 8'h00, 2);
        chk("rd2_tx",  tx0, 8'h5C);
        chk("rd2_lat", lat0, 4);
`ifdef SPI_CMD_AUTOINC_EN
        chk("rd2_cnt", tx_cnt - t0, 2);
`else
        chk("rd2_cnt", tx_cnt - t0, 1);
`endif

        frame(8'hFF, 8'h00, 8'h00, 2);
        chk("rd_id", tx0, 8'hA5);
        frame(8'h90, 8'h00, 8'h00, 2);
        chk("rd_oor", tx0, 8'hFF);

        w0 = wr_cnt;
        frame(8'h07, 8'h11, 8'h22, 3);
        exp_regs[63:56] = 8'h11;
`ifdef SPI_CMD_AUTOINC_EN
        exp_regs[7:0] = 8'h22;
        chk("wr7_cnt", wr_cnt - w0, 2);
`else
        chk("wr7_cnt", wr_cnt - w0, 1);
`endif
        chk("wr7_regs", regs, exp_regs);

        w0 = wr_cnt;
        frame(8'h10, 8'h33, 8'h00, 2);
        chk("oor_regs",   regs, exp_regs);
        chk("oor_strobe", wr_cnt - w0, 0);
        chk("oor_ferr",   frame_err, 1);

        frame(8'h01, 8'h77, 8'h00, 2);
        exp_regs[15:8] = 8'h77;
        chk("wr1_regs", regs, exp_regs);
        chk("ferr_sticky", frame_err, 1);

        frame(8'h81, 8'h00, 8'h00, 2);
        chk("rd1_tx", tx0, 8'h77);
`ifdef SPI_CMD_AUTOINC_EN
        chk("tx_hold", bus.oTx, 8'h5C);
`else
        chk("tx_hold", bus.oTx, 8'h77);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
